// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer: finds the top-most full row, issues one shift per full row,
// waits for the board ack, re-scans, and reports the number of lines cleared.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start
// S_SCAN   | pick top-most full row or finish
// S_WAIT   | shift_req held, waiting for shift_done or timeout
// S_SETTLE | let rowfull reflect the applied shift before re-scanning
// S_DONE   | one-cycle done pulse, lines_cleared published
module line_clear_ctrl #(
  parameter int ROWS        = 23,
  parameter int MAX_CLEAR   = 4,
  parameter int SETTLE_CYC  = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ROWS-1:0] rowfull,
  output logic            shift_req,
  output logic [ROWS-1:0] shift_mask,
  input  logic            shift_done,
  output logic            busy,
  output logic            done,
  output logic [2:0]      lines_cleared,
  output logic [15:0]     total_lines,
  output logic            err
);

  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [2:0]    MAX_C       = 3'(MAX_CLEAR);
  localparam logic [TW-1:0] TMO_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WAIT, S_SETTLE, S_DONE} state_t;

  state_t          state;
  logic [2:0]      count;
  logic [TW-1:0]   tmo_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            row_found;
  logic [IW-1:0]   top_idx;
  logic [ROWS-1:0] scan_mask;

  // Lowest index wins: scan from the bottom so the last hit is the top-most row.
  always_comb begin
    row_found = 1'b0;
    top_idx   = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (rowfull[i]) begin
        row_found = 1'b1;
        top_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    scan_mask = '0;
    for (int i = 0; i < ROWS; i++) begin
      scan_mask[i] = (IW'(i) <= top_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      count         <= '0;
      tmo_cnt       <= '0;
      settle_cnt    <= '0;
      shift_req     <= 1'b0;
      shift_mask    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SCAN;
            busy  <= 1'b1;
            count <= '0;
            err   <= 1'b0;
          end
        end
        S_SCAN: begin
          if (row_found && (count < MAX_C)) begin
            shift_mask <= scan_mask;
            shift_req  <= 1'b1;
            tmo_cnt    <= '0;
            state      <= S_WAIT;
          end else begin
            done          <= 1'b1;
            lines_cleared <= count;
            state         <= S_DONE;
          end
        end
        S_WAIT: begin
          // Ack has priority over a timeout landing on the same edge.
          if (shift_done) begin
            shift_req  <= 1'b0;
            count      <= count + 3'd1;
            settle_cnt <= '0;
            if (total_lines != 16'hFFFF) total_lines <= total_lines + 16'd1;
            state <= (SETTLE_CYC == 0) ? S_SCAN : S_SETTLE;
          end else if (tmo_cnt == TMO_LAST) begin
            shift_req     <= 1'b0;
            err           <= 1'b1;
            done          <= 1'b1;
            lines_cleared <= count;
            state         <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= S_SCAN;
          else settle_cnt <= settle_cnt + SW'(1);
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: directed and random boards checked
// against an arithmetic board/clear model.
module tb_line_clear_ctrl;

  localparam int ROWS = 23;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [ROWS-1:0] rowfull;
  logic            shift_req;
  logic [ROWS-1:0] shift_mask;
  logic            shift_done;
  logic            busy;
  logic            done;
  logic [2:0]      lines_cleared;
  logic [15:0]     total_lines;
  logic            err;

  int checks   = 0;
  int failures = 0;
  int exp_total = 0;

  line_clear_ctrl #(.ROWS(ROWS), .MAX_CLEAR(4), .SETTLE_CYC(1), .ACK_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .rowfull(rowfull),
    .shift_req(shift_req), .shift_mask(shift_mask), .shift_done(shift_done),
    .busy(busy), .done(done), .lines_cleared(lines_cleared),
    .total_lines(total_lines), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int top_row(input int b);
    for (int i = 0; i < ROWS; i++) if (b[i]) return i;
    return -1;
  endfunction

  function automatic int mask_of(input int k);
    return (1 << (k + 1)) - 1;
  endfunction

  // Row k disappears, rows above it drop by one, an empty row enters at the top.
  function automatic int shift_board(input int b, input int k);
    int lower, upper;
    lower = b & ((1 << k) - 1);
    upper = b & ~((1 << (k + 1)) - 1);
    return upper | (lower << 1);
  endfunction

  // ack_delay: 0 = shift_done tied high, d>0 = ack after d+1 request cycles, <0 = never.
  task automatic run_seq(input int init, input int ack_delay, input bit poke);
    int  b, k, board, req_idx, hold, ndone, post, exp_lines, exp_lat, cur_mask;
    int  exp_masks[$];
    bit  timeout, req_prev, ack_prev, poked;
    b = init;
    while (exp_masks.size() < 4) begin
      k = top_row(b);
      if (k < 0) break;
      exp_masks.push_back(mask_of(k));
      if (ack_delay < 0) break;
      b = shift_board(b, k);
    end
    timeout   = (ack_delay < 0) && (exp_masks.size() > 0);
    exp_lines = timeout ? 0 : exp_masks.size();
    exp_lat   = timeout ? 257 : 2 + exp_lines * (3 + ((ack_delay < 0) ? 0 : ack_delay));

    @(negedge clk);
    board = init; rowfull = board[ROWS-1:0]; start = 1'b1; shift_done = 1'b0;
    req_prev = 0; ack_prev = 0; req_idx = 0; hold = 0; ndone = 0; post = 0;
    poked = 0; cur_mask = 0;
    for (int cyc = 1; cyc <= 600 && post < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (req_prev && ack_prev) begin
        board   = shift_board(board, top_row(board));
        rowfull = board[ROWS-1:0];
      end
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1);
        chk("err_cleared_by_start", err, 0);
      end
      if (ndone > 0) begin
        post++;
        chk("busy_after_done", busy, 0);
        chk("lines_held", lines_cleared, exp_lines);
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("done_latency", cyc, exp_lat);
          chk("lines_cleared", lines_cleared, exp_lines);
          chk("err_at_done", err, timeout);
          chk("busy_in_done", busy, 1);
          exp_total = (exp_total + exp_lines > 65535) ? 65535 : exp_total + exp_lines;
          chk("total_lines", total_lines, exp_total);
        end
      end
      if (shift_req) begin
        if (!req_prev) begin
          if (req_idx < exp_masks.size()) chk("shift_mask", shift_mask, exp_masks[req_idx]);
          req_idx++;
          hold = 0;
          cur_mask = int'(shift_mask);
        end else begin
          chk("mask_stable", shift_mask, cur_mask);
        end
        hold++;
      end else if (req_prev && timeout) begin
        chk("req_high_cycles", hold, 255);
      end
      if (ack_delay == 0) shift_done = 1'b1;
      else shift_done = (ack_delay > 0) && shift_req && (hold >= ack_delay + 1);
      if (poke && shift_req && hold == 1 && !poked) begin
        start = 1'b1;
        poked = 1;
      end
      req_prev = shift_req;
      ack_prev = shift_done;
    end
    chk("done_count", ndone, 1);
    chk("req_count", req_idx, exp_masks.size());
    shift_done = 1'b0;
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; shift_done = 1'b0; rowfull = '0;
    repeat (2) @(negedge clk);
    chk("rst_shift_req", shift_req, 0);
    chk("rst_shift_mask", shift_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", lines_cleared, 0);
    chk("rst_total", total_lines, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    run_seq(0, 0, 0);                 // no full rows
    run_seq(1 << 22, 0, 0);           // bottom row, ack tied high
    run_seq(32'h0078_0000, 3, 0);     // tetris, rows 19..22
    run_seq(1 << 10, -1, 0);          // ack timeout
    run_seq(32'h0000_4400, 2, 1);     // start pulsed while busy; err cleared

    for (int n = 0; n < 12; n++) begin
      run_seq(int'($urandom & $urandom & 32'h007F_FFFF), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)));
    end

    // Reset while a shift is outstanding.
    @(negedge clk);
    rowfull = 23'h000400; shift_done = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !shift_req; i++) @(negedge clk);
    chk("midwait_req_up", shift_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("midwait_rst_req", shift_req, 0);
    chk("midwait_rst_mask", shift_mask, 0);
    chk("midwait_rst_busy", busy, 0);
    chk("midwait_rst_done", done, 0);
    chk("midwait_rst_lines", lines_cleared, 0);
    chk("midwait_rst_total", total_lines, 0);
    chk("midwait_rst_err", err, 0);
    exp_total = 0;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("midwait_no_done", saw_done, 0);
    chk("midwait_idle", busy, 0);

    run_seq(1 << 22, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
